// File: rtl/postcode_pkg.sv
// postcode_pkg -- shared definitions for the POST-box TESTREQ/TESTACK link.
//
// Holds the host FSM state encoding and the default link timing. The
// receiver uses the same constants, so the host can refuse at elaboration
// a symbol gap that the receiver would not recognise as a symbol end.
//
// Contents:
//   state_t          host FSM states
//   *_DEF            default host timing, in refclk cycles (12 MHz)
//   RECV_TIMEOUT     receiver symbol-end timeout, in refclk cycles
//   DELAY_W          width of the host delay counter
//   delay_load()     converts a phase length in clocks to a counter preload
package postcode_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC_HI,
    ST_RETRY_WAIT,
    ST_SYNC_GAP,
    ST_BIT_HI1,
    ST_BIT_GAP,
    ST_BIT_HI2,
    ST_SYM_END,
    ST_DONE
  } state_t;

  localparam int PULSE_HIGH_DEF = 12;
  localparam int PULSE_GAP_DEF  = 12;
  localparam int SYMBOL_GAP_DEF = 240;
  localparam int RETRY_GAP_DEF  = 6000;
  localparam int MAX_RETRY_DEF  = 15;
  localparam int RECV_TIMEOUT   = 180;
  localparam int DELAY_W        = 16;

  // A phase of N clocks counts N-1 down to 0; the zero cycle is the last one.
  function automatic logic [DELAY_W-1:0] delay_load(input int clocks);
    return DELAY_W'(clocks - 1);
  endfunction

endpackage

// File: rtl/postcode_host_if.sv
// postcode_host_if -- byte-level request/response bundle of the host engine.
//
// Signals:
//   tx_data   [7:0]  byte to send
//   tx_valid         request to send tx_data
//   tx_ready         engine idle; tx_data taken when tx_valid && tx_ready
//   rx_data   [7:0]  byte read back from the adapter
//   rx_valid         one-clock strobe, rx_data valid, transfer complete
//   err_noack        one-clock strobe, adapter never became ready
//
// Modports:
//   master  the client issuing bytes
//   slave   the postcode_host engine
interface postcode_host_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       err_noack;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, err_noack
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, err_noack
  );

endinterface

// File: rtl/postcode_sync2.sv
// postcode_sync2 -- two-flop synchroniser for an asynchronous level input.
//
// Used by the host for TESTACK and by the receiver for TESTREQ.
//
// Ports:
//   clk   destination clock
//   rst   synchronous active-high reset, clears both stages
//   d     asynchronous input
//   q     input resynchronised to clk, two clocks of latency
module postcode_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First stage may go metastable; only the second stage is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/postcode_host.sv
// postcode_host -- machine-side initiator for the POST-box TESTREQ/TESTACK link.
//
// A transfer is one sync symbol (a lone pulse, repeated until the adapter
// answers on TESTACK) followed by eight data symbols, MSB first. A '0' is a
// single TESTREQ pulse, a '1' a double pulse; a long low time ends a symbol.
// TESTACK is sampled on the last cycle of each first pulse to read back one
// adapter bit per symbol, also MSB first.
//
// Ports:
//   refclk    system clock (12 MHz)
//   rst       synchronous active-high reset
//   testreq   TESTREQ to the adapter, registered
//   testack   TESTACK from the adapter, asynchronous
//   bus       slave side of postcode_host_if (tx request, rx result, error)
module postcode_host
  import postcode_pkg::*;
#(
  parameter int PULSE_HIGH   = PULSE_HIGH_DEF,
  parameter int PULSE_GAP    = PULSE_GAP_DEF,
  parameter int SYMBOL_GAP   = SYMBOL_GAP_DEF,
  parameter int RETRY_GAP    = RETRY_GAP_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF,
  parameter int RECV_TIMEOUT = postcode_pkg::RECV_TIMEOUT
) (
  input  logic refclk,
  input  logic rst,
  output logic testreq,
  input  logic testack,
  postcode_host_if.slave bus
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [DELAY_W-1:0] LD_HIGH  = delay_load(PULSE_HIGH);
  localparam logic [DELAY_W-1:0] LD_PGAP  = delay_load(PULSE_GAP);
  localparam logic [DELAY_W-1:0] LD_SGAP  = delay_load(SYMBOL_GAP);
  localparam logic [DELAY_W-1:0] LD_RETRY = delay_load(RETRY_GAP);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  // Timing that the receiver or the counter cannot cope with is rejected
  // when the design is elaborated rather than found on the bench.
  generate
    if (PULSE_HIGH < 4) begin : g_bad_pulse_high
      $error("postcode_host: PULSE_HIGH must be at least 4");
    end
    if (PULSE_GAP < 1 || PULSE_GAP >= RECV_TIMEOUT) begin : g_bad_pulse_gap
      $error("postcode_host: PULSE_GAP must be below the receiver timeout");
    end
    if (SYMBOL_GAP <= RECV_TIMEOUT) begin : g_bad_symbol_gap
      $error("postcode_host: SYMBOL_GAP must exceed the receiver timeout");
    end
    if (RETRY_GAP < 1 || RETRY_GAP > (1 << DELAY_W)) begin : g_bad_retry_gap
      $error("postcode_host: RETRY_GAP does not fit the delay counter");
    end
    if (MAX_RETRY < 1) begin : g_bad_max_retry
      $error("postcode_host: MAX_RETRY must be at least 1");
    end
  endgenerate

  logic ack_s;

  postcode_sync2 u_ack_sync (
    .clk (refclk),
    .rst (rst),
    .d   (testack),
    .q   (ack_s)
  );

  state_t             state, state_d;
  logic [DELAY_W-1:0] delay_cnt, delay_d;
  logic [RETRY_W-1:0] retry, retry_d;
  logic [2:0]         bit_cnt, bit_cnt_d;
  logic [7:0]         sh_tx, sh_tx_d;
  logic [7:0]         sh_rx, sh_rx_d;
  logic [7:0]         rx_data_d;
  logic               rx_valid_d;
  logic               err_noack_d;
  logic               testreq_d;
  logic               last;

  assign bus.tx_ready = (state == ST_IDLE);

  // State register plus every datapath register the FSM owns. testreq is
  // registered from the next state so it lines up exactly with the high
  // states and carries no decode glitches out to the cable.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= ST_IDLE;
      delay_cnt     <= '0;
      retry         <= '0;
      bit_cnt       <= '0;
      sh_tx         <= '0;
      sh_rx         <= '0;
      testreq       <= 1'b0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.err_noack <= 1'b0;
    end else begin
      state         <= state_d;
      delay_cnt     <= delay_d;
      retry         <= retry_d;
      bit_cnt       <= bit_cnt_d;
      sh_tx         <= sh_tx_d;
      sh_rx         <= sh_rx_d;
      testreq       <= testreq_d;
      bus.rx_data   <= rx_data_d;
      bus.rx_valid  <= rx_valid_d;
      bus.err_noack <= err_noack_d;
    end
  end

  // Next-state logic. Each timed state is entered with its length preloaded
  // into delay_cnt, counts down, and acts on the cycle the count is zero.
  always_comb begin
    state_d     = state;
    delay_d     = delay_cnt;
    retry_d     = retry;
    bit_cnt_d   = bit_cnt;
    sh_tx_d     = sh_tx;
    sh_rx_d     = sh_rx;
    rx_data_d   = bus.rx_data;
    rx_valid_d  = 1'b0;
    err_noack_d = 1'b0;
    last        = (delay_cnt == '0);

    if (!last && state != ST_IDLE && state != ST_DONE) begin
      delay_d = delay_cnt - 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (bus.tx_valid) begin
          sh_tx_d   = bus.tx_data;
          sh_rx_d   = '0;
          bit_cnt_d = 3'd7;
          retry_d   = '0;
          delay_d   = LD_HIGH;
          state_d   = ST_SYNC_HI;
        end
      end

      ST_SYNC_HI: begin
        if (last) begin
          if (ack_s) begin
            delay_d = LD_SGAP;
            state_d = ST_SYNC_GAP;
          end else if (retry != RETRY_LAST) begin
            retry_d = retry + 1'b1;
            delay_d = LD_RETRY;
            state_d = ST_RETRY_WAIT;
          end else begin
            err_noack_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_RETRY_WAIT: begin
        if (last) begin
          delay_d = LD_HIGH;
          state_d = ST_SYNC_HI;
        end
      end

      ST_SYNC_GAP: begin
        if (last) begin
          delay_d = LD_HIGH;
          state_d = ST_BIT_HI1;
        end
      end

      // The adapter presents its read-back bit during the first pulse of
      // every symbol, so that is the only place sh_rx is loaded.
      ST_BIT_HI1: begin
        if (last) begin
          sh_rx_d = {sh_rx[6:0], ack_s};
          if (sh_tx[7]) begin
            delay_d = LD_PGAP;
            state_d = ST_BIT_GAP;
          end else begin
            delay_d = LD_SGAP;
            state_d = ST_SYM_END;
          end
        end
      end

      ST_BIT_GAP: begin
        if (last) begin
          delay_d = LD_HIGH;
          state_d = ST_BIT_HI2;
        end
      end

      ST_BIT_HI2: begin
        if (last) begin
          delay_d = LD_SGAP;
          state_d = ST_SYM_END;
        end
      end

      ST_SYM_END: begin
        if (last) begin
          sh_tx_d = {sh_tx[6:0], 1'b0};
          if (bit_cnt == 3'd0) begin
            rx_data_d  = sh_rx;
            rx_valid_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            bit_cnt_d = bit_cnt - 3'd1;
            delay_d   = LD_HIGH;
            state_d   = ST_BIT_HI1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    testreq_d = (state_d == ST_SYNC_HI) || (state_d == ST_BIT_HI1) ||
                (state_d == ST_BIT_HI2);
  end

endmodule
